alu_6502: RTL and testbench

//  8-bit 6502-style (NES 2A03) arithmetic/logic unit. Sits beside the data bus: operands arrive on a/b

---
 rtl/alu_6502.sv | 177 +++++++++++++++++
 tb/tb_alu_6502.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_6502.sv
// alu_6502: 8-bit 6502 (2A03) ALU with registered result, updated STATUS and a done strobe.
// Latency: one clock from issue to dout/status_out/wout; one operation accepted every clock.
// Backpressure: none; func/a/b may change every cycle, undefined codes and NOP leave outputs held.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   func              operation code, 8'h00 = idle
//   status_in         current STATUS {N,V,-,B,D,I,Z,C}
//   a, b              operands (a alone for unary ops)
//   dout, status_out  registered result and updated STATUS
//   wout              high for exactly the cycles in which a fresh result is presented
//
// Build option: define DECIMAL_MODE_EN to give ADC/SBC packed-BCD results when D=1
// (flags N/Z/V still follow the binary result, as on NMOS parts). Default: binary only.
module alu_6502 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       func,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dout,
    output logic             wout,
    output logic [WIDTH-1:0] status_out
);

    localparam logic [7:0] OP_ADC  = 8'h01;
    localparam logic [7:0] OP_SBC  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_ORA  = 8'h04;
    localparam logic [7:0] OP_EOR  = 8'h05;
    localparam logic [7:0] OP_ASL  = 8'h06;
    localparam logic [7:0] OP_LSR  = 8'h07;
    localparam logic [7:0] OP_ROL  = 8'h08;
    localparam logic [7:0] OP_ROR  = 8'h09;
    localparam logic [7:0] OP_INC  = 8'h0A;
    localparam logic [7:0] OP_DEC  = 8'h0B;
    localparam logic [7:0] OP_CMP  = 8'h0C;
    localparam logic [7:0] OP_BIT  = 8'h0D;
    localparam logic [7:0] OP_PASS = 8'h0E;

    logic [WIDTH-1:0] dout_q,   dout_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             wout_q,   wout_d;

    logic             c_in;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum9;
    logic [WIDTH:0]   cmp9;

    assign c_in  = status_in[0];
    // SBC is ADC with the second operand inverted; C acts as "no borrow".
    assign b_eff = (func == OP_SBC) ? ~b : b;
    assign sum9  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
    // Compare is a subtract with forced carry-in of 1; carry out means a >= b.
    assign cmp9  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef DECIMAL_MODE_EN
    logic [WIDTH-1:0]  dec_r;
    logic              dec_c;
    logic [5:0]        dlo, dhi;
    logic signed [6:0] slo, shi;
    logic              lo_borrow;

    always_comb begin
        dec_r     = '0;
        dec_c     = 1'b0;
        dlo       = '0;
        dhi       = '0;
        slo       = '0;
        shi       = '0;
        lo_borrow = 1'b0;
        if (func == OP_ADC) begin
            dlo = {2'b0, a[3:0]} + {2'b0, b[3:0]} + {5'b0, c_in};
            if (dlo > 6'd9) dlo = dlo + 6'd6;
            dhi = {2'b0, a[7:4]} + {2'b0, b[7:4]} + {5'b0, (dlo > 6'd15)};
            if (dhi > 6'd9) dhi = dhi + 6'd6;
            dec_r = {dhi[3:0], dlo[3:0]};
            dec_c = (dhi > 6'd15);
        end else begin
            slo = $signed({3'b0, a[3:0]}) - $signed({3'b0, b[3:0]}) - $signed({6'b0, ~c_in});
            lo_borrow = slo[6];
            if (lo_borrow) slo = slo - 7'sd6;
            shi = $signed({3'b0, a[7:4]}) - $signed({3'b0, b[7:4]}) - $signed({6'b0, lo_borrow});
            if (shi[6]) shi = shi - 7'sd6;
            dec_r = {shi[3:0], slo[3:0]};
            // On NMOS parts the decimal SBC carry is the binary one.
            dec_c = sum9[WIDTH];
        end
    end
`endif

    always_comb begin
        logic [WIDTH-1:0] r;
        logic             op_ok;
        logic             n_f, v_f, z_f, c_f;

        r      = '0;
        op_ok  = 1'b1;
        n_f    = status_in[7];
        v_f    = status_in[6];
        z_f    = status_in[1];
        c_f    = status_in[0];

        dout_d   = dout_q;
        status_d = status_q;
        wout_d   = 1'b0;

        case (func)
            OP_ADC, OP_SBC: begin
                r   = sum9[WIDTH-1:0];
                c_f = sum9[WIDTH];
                // Overflow: same-signed effective operands giving a result of the other sign.
                v_f = (a[7] == b_eff[7]) && (r[7] != a[7]);
            end
            OP_AND:  r = a & b;
            OP_ORA:  r = a | b;
            OP_EOR:  r = a ^ b;
            OP_ASL: begin r = {a[6:0], 1'b0}; c_f = a[7]; end
            OP_LSR: begin r = {1'b0, a[7:1]}; c_f = a[0]; end
            OP_ROL: begin r = {a[6:0], c_in}; c_f = a[7]; end
            OP_ROR: begin r = {c_in, a[7:1]}; c_f = a[0]; end
            OP_INC:  r = a + 8'd1;
            OP_DEC:  r = a - 8'd1;
            OP_CMP: begin
                r   = cmp9[WIDTH-1:0];
                c_f = cmp9[WIDTH];
            end
            OP_BIT:  r = a & b;
            OP_PASS: r = a;
            default: op_ok = 1'b0;
        endcase

        // N/Z follow the computed value; BIT takes N/V from b instead.
        n_f = r[7];
        z_f = (r == '0);
        if (func == OP_BIT) begin
            n_f = b[7];
            v_f = b[6];
        end

        // CMP and BIT only set flags; the accumulator value passes through.
        if (func == OP_CMP || func == OP_BIT) r = a;

`ifdef DECIMAL_MODE_EN
        if ((func == OP_ADC || func == OP_SBC) && status_in[3]) begin
            r   = dec_r;
            c_f = dec_c;
        end
`endif

        if (op_ok) begin
            dout_d   = r;
            status_d = {n_f, v_f, status_in[5:2], z_f, c_f};
            wout_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= '0;
            status_q <= '0;
            wout_q   <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            status_q <= status_d;
            wout_q   <= wout_d;
        end
    end

    assign dout       = dout_q;
    assign status_out = status_q;
    assign wout       = wout_q;

endmodule

// File: tb/tb_alu_6502.sv
// Directed and random checks of alu_6502 against an arithmetic reference model.
module tb_alu_6502;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] func, status_in, a, b;
    logic [7:0] dout, status_out;
    logic       wout;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_dout = 8'h00;
    logic [7:0] exp_stat = 8'h00;
    logic       exp_w    = 1'b0;

    alu_6502 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .func      (func),
        .status_in (status_in),
        .a         (a),
        .b         (b),
        .dout      (dout),
        .wout      (wout),
        .status_out(status_out)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Behavioural model: flags derived from integer arithmetic.
    function automatic void model(input logic [7:0] f, input logic [7:0] av, input logic [7:0] bv,
                                  input logic [7:0] s, output logic ok,
                                  output logic [7:0] r, output logic [7:0] st);
        int ia, ib, c, sa, sb, t, res;
        logic n, z, cf, v;
        ia = int'(av); ib = int'(bv); c = int'(s[0]);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        cf = s[0]; v = s[6]; ok = 1'b1; res = 0;
        case (f)
            8'h01: begin t = ia + ib + c; res = t % 256; cf = (t > 255);
                         v = (sa + sb + c > 127) || (sa + sb + c < -128); end
            8'h02: begin t = ia - ib - (1 - c); res = (t + 256) % 256; cf = (t >= 0);
                         v = (sa - sb - (1 - c) > 127) || (sa - sb - (1 - c) < -128); end
            8'h03: res = ia & ib;
            8'h04: res = ia | ib;
            8'h05: res = ia ^ ib;
            8'h06: begin res = (ia * 2) % 256;     cf = (ia >= 128); end
            8'h07: begin res = ia / 2;             cf = (ia % 2) == 1; end
            8'h08: begin res = (ia * 2) % 256 + c; cf = (ia >= 128); end
            8'h09: begin res = ia / 2 + 128 * c;   cf = (ia % 2) == 1; end
            8'h0A: res = (ia + 1) % 256;
            8'h0B: res = (ia + 255) % 256;
            8'h0C: res = ia;
            8'h0D: res = ia;
            8'h0E: res = ia;
            default: ok = 1'b0;
        endcase
        n = (res >= 128);
        z = (res == 0);
        if (f == 8'h0C) begin
            cf = (ia >= ib); z = (ia == ib); n = (((ia - ib + 256) % 256) >= 128);
        end
        if (f == 8'h0D) begin
            z = ((ia & ib) == 0); n = (ib >= 128); v = ((ib / 64) % 2) == 1;
        end
`ifdef DECIMAL_MODE_EN
        // Decimal results for valid BCD operands; N/Z/V keep the binary view.
        if (s[3] && f == 8'h01) begin
            t = bcd2int(av) + bcd2int(bv) + c;
            cf = (t > 99); res = int'(int2bcd(t % 100));
        end
        if (s[3] && f == 8'h02) begin
            t = bcd2int(av) - bcd2int(bv) - (1 - c);
            res = int'(int2bcd((t + 100) % 100));
        end
`endif
        r  = 8'(res);
        st = {n, v, s[5:2], z, cf};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] f, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] s, input string tag);
        logic ok;
        logic [7:0] r, st;
        @(negedge clk);
        reset = rst; func = f; a = av; b = bv; status_in = s;
        @(posedge clk);
        #1;
        model(f, av, bv, s, ok, r, st);
        if (rst) begin
            exp_dout = 8'h00; exp_stat = 8'h00; exp_w = 1'b0;
        end else if (ok) begin
            exp_dout = r; exp_stat = st; exp_w = 1'b1;
        end else begin
            exp_w = 1'b0;
        end
        chk({tag, "_dout"}, dout, exp_dout);
        chk({tag, "_st"},   status_out, exp_stat);
        chk({tag, "_w"},    {7'b0, wout}, {7'b0, exp_w});
    endtask

    initial begin
        logic [7:0] f, s;
        reset = 1'b1; func = 8'h00; a = 8'h00; b = 8'h00; status_in = 8'h00;

        // Reset, including an op issued during the reset cycle.
        step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, "rst0");
        step(1'b1, 8'h01, 8'h50, 8'h50, 8'h00, "rst_op");

        // Directed cases.
        step(1'b0, 8'h01, 8'h50, 8'h50, 8'h00, "adc50");
        chk("adc50_const_dout", dout, 8'hA0);
        chk("adc50_const_st", status_out, 8'hC0);
        step(1'b0, 8'h00, 8'h11, 8'h22, 8'hFF, "nop_hold");
        chk("nop_const_dout", dout, 8'hA0);
        step(1'b0, 8'h01, 8'hFF, 8'h01, 8'h00, "adc_wrap");
        chk("adc_wrap_const_st", status_out, 8'h03);
        step(1'b0, 8'h02, 8'h00, 8'h01, 8'h01, "sbc_borrow");
        chk("sbc_const_dout", dout, 8'hFF);
        chk("sbc_const_st", status_out, 8'h80);
        step(1'b0, 8'h03, 8'hF0, 8'h3C, 8'h41, "and");
        chk("and_const_st", status_out, 8'h41);
        step(1'b0, 8'h04, 8'hF0, 8'h0F, 8'h00, "ora");
        step(1'b0, 8'h05, 8'hFF, 8'hFF, 8'h41, "eor");
        step(1'b0, 8'h06, 8'h81, 8'h00, 8'h00, "asl");
        step(1'b0, 8'h07, 8'h01, 8'h00, 8'h80, "lsr");
        step(1'b0, 8'h09, 8'h01, 8'h00, 8'h01, "ror");
        step(1'b0, 8'h08, 8'h80, 8'h00, 8'h00, "rol");
        step(1'b0, 8'h0A, 8'hFF, 8'h00, 8'h01, "inc");
        chk("inc_const_st", status_out, 8'h03);
        step(1'b0, 8'h0B, 8'h00, 8'h00, 8'h00, "dec");
        step(1'b0, 8'h0C, 8'h10, 8'h20, 8'h00, "cmp");
        chk("cmp_const_dout", dout, 8'h10);
        chk("cmp_const_st", status_out, 8'h80);
        step(1'b0, 8'h0D, 8'h0F, 8'hC0, 8'h00, "bit");
        step(1'b0, 8'h0E, 8'h00, 8'h00, 8'h80, "pass");
        step(1'b0, 8'h0F, 8'h12, 8'h34, 8'h00, "undef");

        // Decimal flag with ADC/SBC.
        step(1'b0, 8'h01, 8'h09, 8'h01, 8'h08, "adc_d09");
`ifdef DECIMAL_MODE_EN
        chk("adc_d09_const", dout, 8'h10);
`else
        chk("adc_d09_const", dout, 8'h0A);
`endif
        step(1'b0, 8'h01, 8'h99, 8'h01, 8'h08, "adc_d99");
`ifdef DECIMAL_MODE_EN
        chk("adc_d99_const", dout, 8'h00);
        chk("adc_d99_const_st", status_out, 8'h89);
`else
        chk("adc_d99_const", dout, 8'h9A);
        chk("adc_d99_const_st", status_out, 8'h88);
`endif
        step(1'b0, 8'h02, 8'h10, 8'h01, 8'h09, "sbc_d10");

        // Reset in the middle of a back-to-back ADC stream.
        step(1'b0, 8'h01, 8'h12, 8'h34, 8'h00, "b2b0");
        step(1'b0, 8'h01, 8'h56, 8'h78, 8'h01, "b2b1");
        step(1'b1, 8'h01, 8'h9A, 8'hBC, 8'h00, "b2b_rst");
        chk("b2b_rst_const_w", {7'b0, wout}, 8'h00);
        step(1'b0, 8'h01, 8'h01, 8'h02, 8'h00, "b2b_after");

        // Random stream: codes include NOP and undefined ones, occasional reset.
        for (int i = 0; i < 400; i++) begin
            f = 8'($urandom_range(0, 18));
            s = 8'($urandom);
`ifdef DECIMAL_MODE_EN
            s[3] = 1'b0;
`endif
            step(($urandom_range(0, 40) == 0), f, 8'($urandom), 8'($urandom), s, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
